// File: rtl/nec_ir_receiver_if.sv
// IR receiver bus: raw IR line in, decoded frame and status pulses out.
// master = receiver side, slave = consumer/driver side.
interface nec_ir_receiver_if;
  logic        IRDA_RXD;
  logic [15:0] ADDR;
  logic [7:0]  CMD;
  logic        VALID;
  logic        REPEAT;
  logic        ERR;
  logic        BUSY;

  modport master (input IRDA_RXD, output ADDR, CMD, VALID, REPEAT, ERR, BUSY);
  modport slave  (output IRDA_RXD, input ADDR, CMD, VALID, REPEAT, ERR, BUSY);
endinterface

// File: rtl/nec_ir_receiver.sv
// NEC IR frame decoder: synchroniser + glitch filter, one duration counter,
// and a pulse-width FSM that emits VALID / REPEAT / ERR one-cycle pulses.
module nec_ir_receiver #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TOL_PCT    = 25,
  parameter int GLITCH_CYC = 50,
  parameter bit EXTENDED   = 1'b0,
  parameter bit REPEAT_EN  = 1'b1
)(
  input logic                 CLOCK_50,
  input logic                 RESET,
  nec_ir_receiver_if.master   ir
);

  function automatic longint win_cyc(input longint us, input longint pct);
    return (us * pct * longint'(CLK_HZ)) / 100_000_000;
  endfunction

  localparam longint LO = 100 - TOL_PCT;
  localparam longint HI = 100 + TOL_PCT;

  localparam int LM_MIN = int'(win_cyc(9000, LO));
  localparam int LM_MAX = int'(win_cyc(9000, HI));
  localparam int FS_MIN = int'(win_cyc(4500, LO));
  localparam int FS_MAX = int'(win_cyc(4500, HI));
  localparam int RS_MIN = int'(win_cyc(2250, LO));
  localparam int RS_MAX = int'(win_cyc(2250, HI));
  // bit mark, zero space and stop mark all share the 560 us nominal
  localparam int SH_MIN = int'(win_cyc(560, LO));
  localparam int SH_MAX = int'(win_cyc(560, HI));
  localparam int OS_MIN = int'(win_cyc(1690, LO));
  localparam int OS_MAX = int'(win_cyc(1690, HI));

  localparam int SAT = LM_MAX + 1;
  localparam int CW  = $clog2(SAT + 1);
  localparam int GW  = $clog2(GLITCH_CYC + 1);

  localparam logic [CW-1:0] LM_LO = CW'(LM_MIN), LM_HI = CW'(LM_MAX);
  localparam logic [CW-1:0] FS_LO = CW'(FS_MIN), FS_HI = CW'(FS_MAX);
  localparam logic [CW-1:0] RS_LO = CW'(RS_MIN), RS_HI = CW'(RS_MAX);
  localparam logic [CW-1:0] SH_LO = CW'(SH_MIN), SH_HI = CW'(SH_MAX);
  localparam logic [CW-1:0] OS_LO = CW'(OS_MIN), OS_HI = CW'(OS_MAX);
  localparam logic [CW-1:0] SAT_C = CW'(SAT);
  localparam logic [GW-1:0] G_LAST = GW'(GLITCH_CYC - 1);

  function automatic logic in_win(input logic [CW-1:0] c, input logic [CW-1:0] lo,
                                  input logic [CW-1:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

  typedef enum logic [3:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE,
    STOP_MARK, REP_STOP, CHECK, WAIT_IDLE
  } state_t;

  logic [1:0]    sync;
  logic          filt, filt_q;
  logic [GW-1:0] gcnt;
  logic [CW-1:0] cnt;
  logic          fall, rise;

  state_t        state;
  logic [31:0]   sr;
  logic [4:0]    bidx;
  logic          held;
  logic [15:0]   addr_q;
  logic [7:0]    cmd_q;
  logic          valid_q, rep_q, err_q;
  logic          frame_ok;

  // filtered line only moves after GLITCH_CYC consecutive disagreeing samples
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync   <= 2'b11;
      filt   <= 1'b1;
      filt_q <= 1'b1;
      gcnt   <= '0;
    end else begin
      sync   <= {sync[0], ir.IRDA_RXD};
      filt_q <= filt;
      if (sync[1] == filt) gcnt <= '0;
      else if (gcnt == G_LAST) begin
        filt <= sync[1];
        gcnt <= '0;
      end else gcnt <= gcnt + 1'b1;
    end
  end

  assign fall = filt_q & ~filt;
  assign rise = ~filt_q & filt;

  // on an edge cnt holds exactly the length of the level that just ended
  always_ff @(posedge CLOCK_50) begin
    if (RESET)             cnt <= '0;
    else if (fall || rise) cnt <= CW'(1);
    else if (cnt != SAT_C) cnt <= cnt + 1'b1;
  end

  assign frame_ok = (sr[31:24] == ~sr[23:16]) && (EXTENDED || (sr[15:8] == ~sr[7:0]));

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state   <= IDLE;
      sr      <= '0;
      bidx    <= '0;
      held    <= 1'b0;
      addr_q  <= '0;
      cmd_q   <= '0;
      valid_q <= 1'b0;
      rep_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      rep_q   <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE:       if (fall) state <= LEAD_MARK;
        // a bad leader is treated as noise, not a frame error
        LEAD_MARK:  if (rise) state <= in_win(cnt, LM_LO, LM_HI) ? LEAD_SPACE : IDLE;
                    else if (cnt > LM_HI) state <= IDLE;
        LEAD_SPACE: if (fall) begin
                      if (in_win(cnt, FS_LO, FS_HI)) begin
                        state <= BIT_MARK;
                        bidx  <= '0;
                      end else if (in_win(cnt, RS_LO, RS_HI)) state <= REP_STOP;
                      else begin err_q <= 1'b1; held <= 1'b0; state <= WAIT_IDLE; end
                    end else if (cnt > FS_HI) begin
                      err_q <= 1'b1; held <= 1'b0; state <= WAIT_IDLE;
                    end
        BIT_MARK:   if (rise) begin
                      if (in_win(cnt, SH_LO, SH_HI)) state <= BIT_SPACE;
                      else begin err_q <= 1'b1; held <= 1'b0; state <= WAIT_IDLE; end
                    end else if (cnt > SH_HI) begin
                      err_q <= 1'b1; held <= 1'b0; state <= WAIT_IDLE;
                    end
        BIT_SPACE:  if (fall) begin
                      if (in_win(cnt, SH_LO, SH_HI) || in_win(cnt, OS_LO, OS_HI)) begin
                        sr    <= {in_win(cnt, OS_LO, OS_HI), sr[31:1]};
                        bidx  <= bidx + 1'b1;
                        state <= (bidx == 5'd31) ? STOP_MARK : BIT_MARK;
                      end else begin err_q <= 1'b1; held <= 1'b0; state <= WAIT_IDLE; end
                    end else if (cnt > OS_HI) begin
                      err_q <= 1'b1; held <= 1'b0; state <= WAIT_IDLE;
                    end
        // decision is taken on the stop edge so VALID/ERR show up during CHECK
        STOP_MARK:  if (rise) begin
                      if (in_win(cnt, SH_LO, SH_HI) && frame_ok) begin
                        valid_q <= 1'b1;
                        held    <= 1'b1;
                        addr_q  <= sr[15:0];
                        cmd_q   <= sr[23:16];
                      end else begin
                        err_q <= 1'b1;
                        held  <= 1'b0;
                      end
                      state <= CHECK;
                    end else if (cnt > SH_HI) begin
                      err_q <= 1'b1; held <= 1'b0; state <= WAIT_IDLE;
                    end
        CHECK:      state <= err_q ? WAIT_IDLE : IDLE;
        REP_STOP:   if (rise) begin
                      if (in_win(cnt, SH_LO, SH_HI) && REPEAT_EN && held) begin
                        rep_q <= 1'b1;
                        state <= IDLE;
                      end else begin err_q <= 1'b1; held <= 1'b0; state <= WAIT_IDLE; end
                    end else if (cnt > SH_HI) begin
                      err_q <= 1'b1; held <= 1'b0; state <= WAIT_IDLE;
                    end
        WAIT_IDLE:  if (filt && cnt >= FS_HI) state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  assign ir.ADDR   = addr_q;
  assign ir.CMD    = cmd_q;
  assign ir.VALID  = valid_q;
  assign ir.REPEAT = rep_q;
  assign ir.ERR    = err_q;
  assign ir.BUSY   = (state != IDLE);

endmodule

// File: tb/tb_nec_ir_receiver.sv
// Randomised NEC frame bench: a slow clock keeps frames short in cycles and
// a byte-level model predicts VALID/REPEAT/ERR and the held ADDR/CMD.
module tb_nec_ir_receiver;
  localparam int CLK_HZ = 50_000;
  localparam int CPU    = 1_000_000 / CLK_HZ;  // us per clock
  localparam int GC     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  always #5 clk = ~clk;

  nec_ir_receiver_if ir ();
  nec_ir_receiver_if irx ();
  assign ir.IRDA_RXD  = rxd;
  assign irx.IRDA_RXD = rxd;

  nec_ir_receiver #(.CLK_HZ(CLK_HZ), .GLITCH_CYC(GC)) dut (
    .CLOCK_50(clk), .RESET(rst), .ir(ir.master));
  nec_ir_receiver #(.CLK_HZ(CLK_HZ), .GLITCH_CYC(GC), .EXTENDED(1'b1)) dut_x (
    .CLOCK_50(clk), .RESET(rst), .ir(irx.master));

  int tests = 0, fails = 0;
  int nv = 0, nr = 0, ne = 0, nvx = 0, n_excl = 0, n_addr_bad = 0;
  logic [15:0] pa = '0;
  logic [7:0]  pc = '0;

  // reference state: last accepted frame and whether a repeat may follow
  logic [15:0] m_addr = '0;
  logic [7:0]  m_cmd  = '0;
  bit          m_held = 1'b0;

  always @(posedge clk) begin
    #1;
    if (ir.VALID)  nv++;
    if (ir.REPEAT) nr++;
    if (ir.ERR)    ne++;
    if (irx.VALID) nvx++;
    if (int'(ir.VALID) + int'(ir.REPEAT) + int'(ir.ERR) > 1) n_excl++;
    if (!rst && !ir.VALID && (ir.ADDR !== pa || ir.CMD !== pc)) n_addr_bad++;
    pa = ir.ADDR;
    pc = ir.CMD;
  end

  function automatic bit frame_ok(input logic [31:0] d, input bit ext);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
    return (b[3] == ~b[2]) && (ext || (b[1] == ~b[0]));
  endfunction

  task automatic model_frame(input logic [31:0] d, output bit ok);
    ok = frame_ok(d, 1'b0);
    if (ok) begin
      m_addr = d[15:0];
      m_cmd  = d[23:16];
    end
    m_held = ok;
  endtask

  function automatic int dur(input int us, input bit jit);
    if (jit) return int'(us * int'($urandom_range(80, 120)) / 100 / CPU);
    return us / CPU;
  endfunction

  task automatic seg(input logic lvl, input int cyc);
    rxd = lvl;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] d, input bit jit, input int stretch_bit,
                            input bit glitch, input int abort_bit);
    seg(1'b0, dur(9000, jit));
    if (glitch) begin
      seg(1'b1, 100);
      seg(1'b0, GC - 1);
      seg(1'b1, dur(4500, 1'b0) - 100 - (GC - 1));
    end else seg(1'b1, dur(4500, jit));
    for (int i = 0; i < 32; i++) begin
      if (i == abort_bit) begin
        seg(1'b0, 10);
        return;
      end
      seg(1'b0, dur(560, jit));
      seg(1'b1, (i == stretch_bit) ? 2500 / CPU : dur(d[i] ? 1690 : 560, jit));
    end
    seg(1'b0, dur(560, jit));
    rxd = 1'b1;
  endtask

  task automatic send_repeat();
    seg(1'b0, dur(9000, 1'b0));
    seg(1'b1, dur(2250, 1'b0));
    seg(1'b0, dur(560, 1'b0));
    rxd = 1'b1;
  endtask

  task automatic gap();
    seg(1'b1, 350);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    seg(1'b1, 3);
    tests++;
    if ({ir.ADDR, ir.CMD} !== 24'h0) begin
      fails++; $display("FAIL reset_addr_cmd: got %h want 000000", {ir.ADDR, ir.CMD});
    end
    tests++;
    if ({ir.VALID, ir.REPEAT, ir.ERR, ir.BUSY} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b want 0000", {ir.VALID, ir.REPEAT, ir.ERR, ir.BUSY});
    end
    rst = 1'b0;
    m_addr = '0; m_cmd = '0; m_held = 1'b0;
    seg(1'b1, 5);
  endtask

  task automatic test_nominal();
    int v0 = nv, e0 = ne;
    bit ok;
    send_frame(32'hE916FF00, 1'b0, -1, 1'b0, -1);
    gap();
    model_frame(32'hE916FF00, ok);
    tests++;
    if (nv - v0 !== 1) begin fails++; $display("FAIL nominal_valid: got %0d want 1", nv - v0); end
    tests++;
    if (ne - e0 !== 0) begin fails++; $display("FAIL nominal_err: got %0d want 0", ne - e0); end
    tests++;
    if (ir.ADDR !== 16'hFF00 || ir.CMD !== 8'h16) begin
      fails++; $display("FAIL nominal_data: got %h/%h want ff00/16", ir.ADDR, ir.CMD);
    end
    tests++;
    if (ir.BUSY !== 1'b0) begin fails++; $display("FAIL nominal_busy: got %b want 0", ir.BUSY); end
  endtask

  task automatic test_bad_check();
    int v0 = nv, e0 = ne;
    bit ok;
    send_frame(32'hE816FF00, 1'b0, -1, 1'b0, -1);
    gap();
    model_frame(32'hE816FF00, ok);
    tests++;
    if (nv - v0 !== 0 || ne - e0 !== 1) begin
      fails++; $display("FAIL bad_check_pulses: got v%0d e%0d want v0 e1", nv - v0, ne - e0);
    end
    tests++;
    if (ir.ADDR !== m_addr || ir.CMD !== m_cmd) begin
      fails++; $display("FAIL bad_check_hold: got %h/%h want %h/%h", ir.ADDR, ir.CMD, m_addr, m_cmd);
    end
  endtask

  task automatic test_extended();
    int vx0 = nvx, v0 = nv, e0 = ne;
    bit ok;
    send_frame(32'hE9163412, 1'b0, -1, 1'b0, -1);
    gap();
    model_frame(32'hE9163412, ok);
    tests++;
    if (nvx - vx0 !== 1 || irx.ADDR !== 16'h3412 || irx.CMD !== 8'h16) begin
      fails++; $display("FAIL extended_valid: got n%0d %h/%h want n1 3412/16", nvx - vx0, irx.ADDR, irx.CMD);
    end
    tests++;
    if (nv - v0 !== int'(ok) || ne - e0 !== int'(!ok)) begin
      fails++; $display("FAIL extended_std_dut: got v%0d e%0d want v%0d e%0d", nv - v0, ne - e0, ok, !ok);
    end
  endtask

  task automatic test_repeat();
    int r0, e0;
    bit ok;
    send_frame(32'hE916FF00, 1'b0, -1, 1'b0, -1);
    gap();
    model_frame(32'hE916FF00, ok);
    r0 = nr; e0 = ne;
    send_repeat();
    gap();
    tests++;
    if (nr - r0 !== 1 || ne - e0 !== 0) begin
      fails++; $display("FAIL repeat_pulse: got r%0d e%0d want r1 e0", nr - r0, ne - e0);
    end
    tests++;
    if (ir.CMD !== 8'h16 || ir.ADDR !== 16'hFF00) begin
      fails++; $display("FAIL repeat_hold: got %h/%h want ff00/16", ir.ADDR, ir.CMD);
    end
  endtask

  task automatic test_repeat_after_reset();
    int v0, r0, e0;
    rst = 1'b1;
    seg(1'b1, 2);
    rst = 1'b0;
    m_addr = '0; m_cmd = '0; m_held = 1'b0;
    seg(1'b1, 5);
    v0 = nv; r0 = nr; e0 = ne;
    send_repeat();
    gap();
    tests++;
    if (nv - v0 !== 0 || nr - r0 !== 0 || ne - e0 !== 1) begin
      fails++; $display("FAIL repeat_after_reset: got v%0d r%0d e%0d want v0 r0 e1", nv - v0, nr - r0, ne - e0);
    end
  endtask

  task automatic test_tolerance();
    int v0 = nv, e0 = ne;
    bit ok;
    send_frame(32'hE916FF00, 1'b1, -1, 1'b1, -1);
    gap();
    model_frame(32'hE916FF00, ok);
    tests++;
    if (nv - v0 !== 1 || ne - e0 !== 0) begin
      fails++; $display("FAIL tolerance_glitch: got v%0d e%0d want v1 e0", nv - v0, ne - e0);
    end
    tests++;
    if (ir.ADDR !== m_addr || ir.CMD !== m_cmd) begin
      fails++; $display("FAIL tolerance_data: got %h/%h want %h/%h", ir.ADDR, ir.CMD, m_addr, m_cmd);
    end
  endtask

  task automatic test_stretch();
    int v0 = nv, e0 = ne;
    int sb = int'($urandom_range(0, 31));
    send_frame(32'hE916FF00, 1'b0, sb, 1'b0, -1);
    gap();
    m_held = 1'b0;
    tests++;
    if (nv - v0 !== 0 || ne - e0 !== 1) begin
      fails++; $display("FAIL stretch_bit%0d: got v%0d e%0d want v0 e1", sb, nv - v0, ne - e0);
    end
    tests++;
    if (ir.BUSY !== 1'b0) begin fails++; $display("FAIL stretch_busy: got %b want 0", ir.BUSY); end
  endtask

  task automatic test_short_leader();
    int v0 = nv, r0 = nr, e0 = ne;
    seg(1'b0, 6000 / CPU);
    seg(1'b1, 20);
    tests++;
    if (nv - v0 !== 0 || nr - r0 !== 0 || ne - e0 !== 0) begin
      fails++; $display("FAIL short_leader_pulses: got v%0d r%0d e%0d want 0 0 0", nv - v0, nr - r0, ne - e0);
    end
    tests++;
    if (ir.BUSY !== 1'b0) begin fails++; $display("FAIL short_leader_busy: got %b want 0", ir.BUSY); end
    gap();
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    bit ok;
    logic [31:0] d = 32'hC23DB54A;
    send_frame(d, 1'b0, -1, 1'b0, 12);
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    tests++;
    if ({ir.ADDR, ir.CMD, ir.VALID, ir.REPEAT, ir.ERR, ir.BUSY} !== 28'h0) begin
      fails++; $display("FAIL reset_mid_frame: got %h/%h %b want all zero", ir.ADDR, ir.CMD,
                        {ir.VALID, ir.REPEAT, ir.ERR, ir.BUSY});
    end
    rst = 1'b0;
    m_addr = '0; m_cmd = '0; m_held = 1'b0;
    gap();
    v0 = nv;
    send_frame(d, 1'b0, -1, 1'b0, -1);
    gap();
    model_frame(d, ok);
    tests++;
    if (nv - v0 !== 1 || ir.ADDR !== m_addr || ir.CMD !== m_cmd) begin
      fails++; $display("FAIL after_reset_frame: got n%0d %h/%h want n1 %h/%h", nv - v0, ir.ADDR, ir.CMD, m_addr, m_cmd);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      int v0 = nv, e0 = ne, vx0 = nvx, r0, e1;
      logic [7:0] b0 = 8'($urandom), b2 = 8'($urandom);
      logic [7:0] b1 = ($urandom_range(0, 3) != 0) ? ~b0 : 8'($urandom);
      logic [7:0] b3 = ($urandom_range(0, 3) != 0) ? ~b2 : (~b2 ^ 8'h10);
      logic [31:0] d = {b3, b2, b1, b0};
      bit ok, okx, want_rep;
      okx = frame_ok(d, 1'b1);
      send_frame(d, 1'b1, -1, 1'b0, -1);
      gap();
      model_frame(d, ok);
      tests++;
      if (nv - v0 !== int'(ok) || ne - e0 !== int'(!ok) || nvx - vx0 !== int'(okx)) begin
        fails++; $display("FAIL random%0d_pulses d=%h: got v%0d e%0d vx%0d want v%0d e%0d vx%0d",
                          k, d, nv - v0, ne - e0, nvx - vx0, ok, !ok, okx);
      end
      tests++;
      if (ir.ADDR !== m_addr || ir.CMD !== m_cmd) begin
        fails++; $display("FAIL random%0d_data: got %h/%h want %h/%h", k, ir.ADDR, ir.CMD, m_addr, m_cmd);
      end
      if ($urandom_range(0, 1) == 1) begin
        want_rep = m_held;
        m_held = want_rep;
        r0 = nr; e1 = ne;
        send_repeat();
        gap();
        tests++;
        if (nr - r0 !== int'(want_rep) || ne - e1 !== int'(!want_rep)) begin
          fails++; $display("FAIL random%0d_repeat: got r%0d e%0d want r%0d e%0d",
                            k, nr - r0, ne - e1, want_rep, !want_rep);
        end
      end
    end
  endtask

  task automatic test_invariants();
    tests++;
    if (n_excl !== 0) begin fails++; $display("FAIL pulse_exclusive: got %0d overlaps want 0", n_excl); end
    tests++;
    if (n_addr_bad !== 0) begin fails++; $display("FAIL addr_without_valid: got %0d changes want 0", n_addr_bad); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_check();
    test_extended();
    test_repeat();
    test_repeat_after_reset();
    test_tolerance();
    test_stretch();
    test_short_leader();
    test_reset_mid_frame();
    test_random();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
